payload_fifo: RTL and testbench

//  Synchronous first-word-fall-through FIFO directly downstream of the packet parser.

---
 rtl/payload_fifo.sv | 104 ++++++++++
 tb/tb_payload_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/payload_fifo.sv
// payload_fifo: first-word-fall-through FIFO between the packet parser and the
// egress consumer. Reports occupancy, almost-full/empty flags and a
// high-water mark for debug.
module payload_fifo #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       valid_in,
    output logic                       ready_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    input  logic                       ready_out,
    input  logic                       flush,
    input  logic                       hwm_clr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     hwm
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_CNT   = (AW+1)'(AFULL_THRESH);
    localparam logic [AW:0]   AE_CNT   = (AW+1)'(AEMPTY_THRESH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             wr_en;
    logic             rd_en;

    // Handshake and flag decode. Reset masks the outputs directly so the
    // parser sees ready_in=0 in the same cycle rst is raised.
    assign ready_in     = !rst && (count != FULL_CNT);
    assign valid_out    = !rst && (count != '0);
    assign data_out     = valid_out ? mem[rd_ptr] : '0;
    assign almost_full  = !rst && (count >= AF_CNT);
    assign almost_empty = rst || (count <= AE_CNT);

    // A flush cycle swallows any concurrent transfer.
    assign wr_en = valid_in && ready_in && !flush;
    assign rd_en = valid_out && ready_out && !flush;

    // Next occupancy; shared by the count register and the high-water mark.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
        end
    end

    // High-water mark tracks the registered occupancy; a clear reloads it
    // with the occupancy landing at the same edge rather than zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            hwm <= '0;
        end else if (hwm_clr || (count_nxt > hwm)) begin
            hwm <= count_nxt;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    // Occupancy must match the pointer distance and never exceed DEPTH.
    a_occupancy: assert property (@(posedge clk) disable iff (rst)
        (count <= FULL_CNT) &&
        ((count == FULL_CNT) ? (wr_ptr == rd_ptr)
                             : (count[AW-1:0] == AW'(wr_ptr - rd_ptr))));

endmodule

// File: tb/tb_payload_fifo.sv
// tb_payload_fifo: randomized and directed stimulus with a queue-based
// reference model; a negedge monitor compares DUT outputs against it.
module tb_payload_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AFT   = 12;
    localparam int AET   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             valid_in = 1'b0;
    logic             ready_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             ready_out = 1'b0;
    logic             flush = 1'b0;
    logic             hwm_clr = 1'b0;
    logic [4:0]       count;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       hwm;

    payload_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out), .flush(flush),
        .hwm_clr(hwm_clr), .count(count), .almost_full(almost_full),
        .almost_empty(almost_empty), .hwm(hwm)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of expected words plus occupancy and hwm.
    logic [WIDTH-1:0] exp_q[$];
    int   m_cnt = 0;
    int   m_hwm = 0;
    logic p_wr = 0, p_rd = 0, p_flush = 0, p_rst = 1, p_hclr = 0;
    int   checks = 0;
    int   errors = 0;
    int   rcv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: commit the previous cycle into the model, then drive.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r,
                        input logic f, input logic hc, input logic rs, output logic acc);
        @(posedge clk);
        #1;
        if (p_rst) begin
            m_cnt = 0;
            m_hwm = 0;
        end else begin
            if (p_flush) m_cnt = 0;
            else m_cnt = m_cnt + int'(p_wr) - int'(p_rd);
            if (p_hclr || m_cnt > m_hwm) m_hwm = m_cnt;
        end
        valid_in = v; data_in = d; ready_out = r; flush = f; hwm_clr = hc; rst = rs;
        p_wr    = v && !rs && !f && (m_cnt < DEPTH);
        p_rd    = r && !rs && !f && (m_cnt > 0);
        p_flush = f;
        p_rst   = rs;
        p_hclr  = hc;
        if (rs || f) exp_q.delete();
        else if (p_wr) exp_q.push_back(d);
        acc = p_wr;
    endtask

    logic a;
    task automatic wr(input logic [WIDTH-1:0] d); step(1, d, 0, 0, 0, 0, a); endtask
    task automatic rd();   step(0, '0, 1, 0, 0, 0, a); endtask
    task automatic idle(); step(0, '0, 0, 0, 0, 0, a); endtask

    // Monitor: status checks every cycle, data checks and pops on reads.
    initial begin
        forever begin
            @(negedge clk);
            chk("count", count, m_cnt);
            chk("hwm", hwm, m_hwm);
            chk("ready_in", ready_in, !rst && m_cnt != DEPTH);
            chk("valid_out", valid_out, !rst && m_cnt != 0);
            chk("almost_full", almost_full, !rst && m_cnt >= AFT);
            chk("almost_empty", almost_empty, rst || m_cnt <= AET);
            if (!rst && m_cnt != 0 && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", data_out, 64'hDEAD_BEEF_0000_0000);
                end else begin
                    chk("data_out", data_out, exp_q[0]);
                    if (ready_out) begin
                        void'(exp_q.pop_front());
                        rcv++;
                    end
                end
            end else if (!rst && m_cnt == 0) begin
                chk("data_out_idle", data_out, 0);
            end
        end
    end

    initial begin
        int base;
        int sent;
        int cyc;
        step(0, '0, 0, 0, 0, 1, a);
        step(0, '0, 0, 0, 0, 1, a);
        idle();
        #2;
        chk("rst_count", count, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_ae", almost_empty, 1);

        // Fill with ready_out low; the 17th word must bounce.
        for (int i = 0; i < 17; i++) wr(32'h100 + i);
        #2;
        chk("fill_count", count, 16);
        chk("fill_ready", ready_in, 0);
        chk("fill_af", almost_full, 1);

        // Drain in order.
        for (int i = 0; i < 16; i++) rd();
        idle();
        #2;
        chk("drain_count", count, 0);
        chk("drain_valid", valid_out, 0);
        chk("drain_data", data_out, 0);

        // Flush at 7 then a single write.
        step(0, '0, 0, 0, 0, 1, a);
        for (int i = 0; i < 7; i++) wr(32'h200 + i);
        step(1, 32'h999, 1, 1, 0, 0, a);
        wr(32'hAA);
        idle();
        #2;
        chk("flush_count", count, 1);
        chk("flush_data", data_out, 32'hAA);
        chk("flush_hwm", hwm, 7);

        // Concurrent read/write at count 5, pointers wrap.
        rd();
        for (int i = 0; i < 5; i++) wr(32'h300 + i);
        for (int i = 0; i < 8; i++) step(1, 32'h400 + i, 1, 0, 0, 0, a);
        idle();
        #2;
        chk("conc_count", count, 5);
        for (int i = 0; i < 5; i++) rd();
        idle();

        // Reset at 9.
        for (int i = 0; i < 9; i++) wr(32'h500 + i);
        step(0, '0, 0, 0, 0, 1, a);
        #2;
        chk("rst9_ready", ready_in, 0);
        chk("rst9_valid", valid_out, 0);
        idle();
        #2;
        chk("rst9_count", count, 0);
        chk("rst9_hwm", hwm, 0);

        // High-water mark.
        for (int i = 0; i < 10; i++) wr(32'h600 + i);
        idle();
        #2;
        chk("hwm_10", hwm, 10);
        for (int i = 0; i < 7; i++) rd();
        step(0, '0, 0, 0, 1, 0, a);
        idle();
        #2;
        chk("hwm_clr", hwm, 3);
        for (int i = 0; i < 3; i++) wr(32'h700 + i);
        idle();
        #2;
        chk("hwm_6", hwm, 6);
        for (int i = 0; i < 6; i++) rd();
        idle();

        // Random wrap-around stress of 40 words.
        base = rcv;
        sent = 0;
        cyc  = 0;
        while ((rcv - base) < 40 && cyc < 3000) begin
            step((sent < 40) && ($urandom_range(0, 1) == 1), WIDTH'(sent),
                 $urandom_range(0, 2) != 0, 0, 0, 0, a);
            if (a) sent++;
            cyc++;
        end
        idle();
        idle();
        chk("stress_sent", sent, 40);
        chk("stress_rcv", rcv - base, 40);
        #2;
        chk("stress_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
